// File: rtl/kara_pkg.sv
// kara_pkg: FSM encoding and width helpers for the Karatsuba carry-less multiplier
package kara_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    DONE = 3'd4
  } state_t;
  function automatic int half_w(input int n);
    return n / 2;
  endfunction
  function automatic int pp_w(input int n);
    return 2 * (n / 2) - 1;
  endfunction
  function automatic int prod_w(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/clmul_half.sv
// clmul_half: combinational H x H carry-less multiplier (AND array, XOR reduction)
module clmul_half #(
  parameter int H = 3
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-2:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < H; j++)
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
  end
endmodule

// File: rtl/kara_seq_mul.sv
// kara_seq_mul: sequential Karatsuba carry-less multiplier, one shared half-width multiplier.
// KARA_OUT_REG_EN adds a registered output slot so the FSM can accept the next pair early.
module kara_seq_mul
  import kara_pkg::*;
#(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] out_p
);
  localparam int H  = half_w(N);
  localparam int PW = pp_w(N);
  localparam int OW = prod_w(N);
  state_t         state;
  logic [N-1:0]   a_r, b_r;
  logic [H-1:0]   ma, mb;
  logic [PW-1:0]  pm, p0, p2, pmid;
  logic [OW-1:0]  acc, acc_nxt;
  // the single multiplier sees low halves in LO, high halves in HI, folded halves in MID
  always_comb begin
    ma = state == LO ? a_r[H-1:0] : state == HI ? a_r[N-1:H] : a_r[H-1:0] ^ a_r[N-1:H];
    mb = state == LO ? b_r[H-1:0] : state == HI ? b_r[N-1:H] : b_r[H-1:0] ^ b_r[N-1:H];
    pmid = pm ^ p0 ^ p2;
    acc_nxt = OW'(p0) ^ (OW'(pmid) << H) ^ (OW'(p2) << N);
  end
  clmul_half #(.H(H)) u_mul (.a(ma), .b(mb), .p(pm));
`ifdef KARA_OUT_REG_EN
  logic          slot_v;
  logic [OW-1:0] slot_p;
  assign out_valid = slot_v;
  assign out_p     = slot_p;
`else
  logic valid_r;
  assign out_valid = valid_r;
  assign out_p     = acc;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      a_r      <= '0;
      b_r      <= '0;
      p0       <= '0;
      p2       <= '0;
      acc      <= '0;
`ifdef KARA_OUT_REG_EN
      slot_v   <= 1'b0;
      slot_p   <= '0;
`else
      valid_r  <= 1'b0;
`endif
    end else begin
`ifdef KARA_OUT_REG_EN
      if (slot_v && out_ready) slot_v <= 1'b0;
`endif
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= in_a;
          b_r      <= in_b;
          in_ready <= 1'b0;
          state    <= LO;
        end
        LO: begin
          p0    <= pm;
          state <= HI;
        end
        HI: begin
          p2    <= pm;
          state <= MID;
        end
        MID: begin
          acc   <= acc_nxt;
          state <= DONE;
`ifndef KARA_OUT_REG_EN
          valid_r <= 1'b1;
`endif
        end
        default:
`ifdef KARA_OUT_REG_EN
          if (!slot_v || out_ready) begin
            slot_v   <= 1'b1;
            slot_p   <= acc;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
`else
          if (out_ready) begin
            valid_r  <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
`endif
      endcase
    end
endmodule
